dm_stage: RTL and testbench

//  Data-memory (DM) pipeline stage directly downstream of the EX-stage ALU. Consumes the flopped ALU

---
 rtl/dm_stage_pkg.sv | 18 +
 rtl/dm_timeout_cnt.sv | 32 +++
 rtl/dm_stage.sv | 115 +++++++++++
 tb/tb_dm_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dm_stage_pkg.sv
// Shared types and defaults for the data-memory pipeline stage.
package dm_stage_pkg;

    typedef enum logic {
        DM_IDLE = 1'b0,
        DM_WAIT = 1'b1
    } dm_state_e;

    localparam int unsigned DM_TIMEOUT_DEF  = 64;
    localparam logic [31:0] DM_ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic [4:0]  addr;
    } dm_wb_t;

endpackage

// File: rtl/dm_timeout_cnt.sv
// Cycle counter for an outstanding bus access; tc flags the last allowed wait cycle.
module dm_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tc = (count_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dm_stage.sv
// DM pipeline stage: req/ack bus access with stall, timeout abort and the DM/WB register.
module dm_stage
    import dm_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DM_TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA    = DM_ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dst_EX_DM,
    input  logic [31:0] p0_EX_DM,
    input  logic        re_EX_DM,
    input  logic        we_EX_DM,
    input  logic        rf_we_EX_DM,
    input  logic [4:0]  dst_addr_EX_DM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_DM,
    output logic [31:0] rf_w_data_DM_WB,
    output logic        rf_we_DM_WB,
    output logic [4:0]  dst_addr_DM_WB,
    output logic        bus_err
);
    dm_state_e state_q, state_d;
    dm_wb_t    wb_q, wb_d;
    logic      bus_err_q, bus_err_d;
    logic      op, req, stall, done, cnt_clr, cnt_inc, cnt_tc;

    assign op = re_EX_DM | we_EX_DM;

    dm_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        wb_d      = wb_q;
        bus_err_d = bus_err_q;
        req       = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (op) begin
                    req = 1'b1;
                    if (bus_ack) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_inc = 1'b1;
                        state_d = DM_WAIT;
                    end
                end
            end
            DM_WAIT: begin
                req = 1'b1;
                if (bus_ack || cnt_tc) begin
                    // A timeout completes like an ack so the pipe can never deadlock.
                    done      = 1'b1;
                    cnt_clr   = 1'b1;
                    bus_err_d = bus_err_q | ~bus_ack;
                    state_d   = DM_IDLE;
                end else begin
                    stall   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = DM_IDLE;
        endcase

        if (stall) begin
            wb_d.we = 1'b0;
        end else if (!op) begin
            wb_d = '{data: dst_EX_DM, we: rf_we_EX_DM, addr: dst_addr_EX_DM};
        end else if (done) begin
            wb_d.addr = dst_addr_EX_DM;
            wb_d.we   = rf_we_EX_DM & re_EX_DM;
            wb_d.data = !re_EX_DM ? dst_EX_DM : (bus_ack ? bus_rdata : ERR_DATA);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DM_IDLE;
            wb_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Request and stall are combinational, so gate them with reset to drop them at once.
    assign bus_req         = req & ~rst;
    assign stall_DM        = stall & ~rst;
    assign bus_we          = we_EX_DM;
    assign bus_addr        = dst_EX_DM;
    assign bus_wdata       = p0_EX_DM;
    assign rf_w_data_DM_WB = wb_q.data;
    assign rf_we_DM_WB     = wb_q.we;
    assign dst_addr_DM_WB  = wb_q.addr;
    assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_dm_stage.sv
// Randomized bench for dm_stage against a per-instruction timing model.
module tb_dm_stage;
    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dst_EX_DM, p0_EX_DM, bus_rdata;
    logic        re_EX_DM, we_EX_DM, rf_we_EX_DM, bus_ack;
    logic [4:0]  dst_addr_EX_DM;
    logic        bus_req, bus_we, stall_DM, rf_we_DM_WB, bus_err;
    logic [31:0] bus_addr, bus_wdata, rf_w_data_DM_WB;
    logic [4:0]  dst_addr_DM_WB;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic err_m   = 1'b0;
    int   st;

    always #5 clk = ~clk;

    dm_stage #(.TIMEOUT_CYC(T), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .dst_EX_DM(dst_EX_DM), .p0_EX_DM(p0_EX_DM),
        .re_EX_DM(re_EX_DM), .we_EX_DM(we_EX_DM),
        .rf_we_EX_DM(rf_we_EX_DM), .dst_addr_EX_DM(dst_addr_EX_DM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall_DM(stall_DM),
        .rf_w_data_DM_WB(rf_w_data_DM_WB), .rf_we_DM_WB(rf_we_DM_WB),
        .dst_addr_DM_WB(dst_addr_DM_WB), .bus_err(bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one instruction, starting just after a clock edge. d is the cycle (0 = same
    // cycle) on which the slave acks; d < 0 means never. For non-memory ops d == 0 forces a
    // spurious ack and d > 0 gives random spurious acks.
    task automatic run_instr(input logic re, input logic we, input logic rfw,
                             input logic [31:0] dst, input logic [31:0] p0, input logic [4:0] da,
                             input int d, input logic [31:0] rd, output int stalls);
        logic        op;
        logic        acked;
        int          done_k;
        logic [31:0] rd_ack;
        logic [31:0] exp_data;
        op     = re | we;
        acked  = op && d >= 0 && d <= T - 1;
        done_k = !op ? 0 : (acked ? d : T - 1);
        rd_ack = '0;
        stalls = 0;
        re_EX_DM = re; we_EX_DM = we; rf_we_EX_DM = rfw;
        dst_EX_DM = dst; p0_EX_DM = p0; dst_addr_EX_DM = da;
        for (int k = 0; k <= done_k; k++) begin
            bus_rdata = $urandom;
            if (op) begin
                bus_ack = (k == d);
                if (k == d) begin
                    bus_rdata = rd;
                    rd_ack    = rd;
                end
            end else begin
                bus_ack = (d == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
            chk("bus_req", 32'(bus_req), 32'(op));
            chk("stall_DM", 32'(stall_DM), 32'(op && k < done_k));
            if (stall_DM) stalls++;
            if (op) begin
                chk("bus_we", 32'(bus_we), 32'(we));
                chk("bus_addr", bus_addr, dst);
                chk("bus_wdata", bus_wdata, p0);
            end
            @(posedge clk); #1;
            if (k < done_k) chk("wb_we_bubble", 32'(rf_we_DM_WB), 32'd0);
        end
        bus_ack = 1'b0;
        if (op && !acked) err_m = 1'b1;
        exp_data = !re ? dst : (acked ? rd_ack : ERR);
        chk("wb_we", 32'(rf_we_DM_WB), 32'(rfw && !we));
        chk("wb_addr", 32'(dst_addr_DM_WB), 32'(da));
        if (!we) chk("wb_data", rf_w_data_DM_WB, exp_data);
        chk("bus_err", 32'(bus_err), 32'(err_m));
    endtask

    initial begin
        rst = 1'b1;
        re_EX_DM = 0; we_EX_DM = 0; rf_we_EX_DM = 0; bus_ack = 0;
        dst_EX_DM = '0; p0_EX_DM = '0; dst_addr_EX_DM = '0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stall_DM), 32'd0);
        chk("rst_wb_data", rf_w_data_DM_WB, 32'd0);
        chk("rst_wb_we", 32'(rf_we_DM_WB), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU pass-through
        run_instr(0, 0, 1, 32'h1234_5678, 32'h0, 5'd5, 1, 32'h0, st);
        chk("lit_alu_data", rf_w_data_DM_WB, 32'h1234_5678);
        chk("lit_alu_we", 32'(rf_we_DM_WB), 32'd1);
        chk("lit_alu_addr", 32'(dst_addr_DM_WB), 32'd5);

        // Zero-wait load
        run_instr(1, 0, 1, 32'h0000_0040, 32'h0, 5'd7, 0, 32'hCAFE_0001, st);
        chk("lit_ld0_stalls", 32'(st), 32'd0);
        chk("lit_ld0_data", rf_w_data_DM_WB, 32'hCAFE_0001);

        // Store acked after three waits
        run_instr(0, 1, 1, 32'h0000_0010, 32'hA5A5_A5A5, 5'd3, 3, 32'h0, st);
        chk("lit_st_stalls", 32'(st), 32'd3);
        chk("lit_st_we", 32'(rf_we_DM_WB), 32'd0);

        // Ack on the terminal wait cycle still wins over the timeout
        run_instr(1, 0, 1, 32'h0000_0044, 32'h0, 5'd9, T - 1, 32'h0BAD_F00D, st);
        chk("lit_ld_last_data", rf_w_data_DM_WB, 32'h0BAD_F00D);
        chk("lit_ld_last_err", 32'(bus_err), 32'd0);

        // Load that never completes
        run_instr(1, 0, 1, 32'h0000_0080, 32'h0, 5'd4, -1, 32'h0, st);
        chk("lit_to_stalls", 32'(st), 32'd7);
        chk("lit_to_data", rf_w_data_DM_WB, 32'hDEAD_BEEF);
        chk("lit_to_err", 32'(bus_err), 32'd1);

        // Spurious ack with no access, then a normal load
        run_instr(0, 0, 1, 32'h0000_0777, 32'h0, 5'd2, 0, 32'h0, st);
        chk("lit_spur_data", rf_w_data_DM_WB, 32'h0000_0777);
        run_instr(1, 0, 1, 32'h0000_0048, 32'h0, 5'd6, 2, 32'h1111_2222, st);
        chk("lit_after_spur_stalls", 32'(st), 32'd2);
        chk("lit_err_sticky", 32'(bus_err), 32'd1);

        // Reset during the second wait cycle of a load
        re_EX_DM = 1; we_EX_DM = 0; rf_we_EX_DM = 1; dst_EX_DM = 32'h50; dst_addr_EX_DM = 5'd8;
        bus_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req_before", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_stall", 32'(stall_DM), 32'd0);
        chk("mid_rst_wb", {rf_w_data_DM_WB[31:6], rf_we_DM_WB, dst_addr_DM_WB}, 32'd0);
        chk("mid_rst_err", 32'(bus_err), 32'd0);
        err_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(1, 0, 1, 32'h0000_0050, 32'h0, 5'd8, 1, 32'h3333_4444, st);
        chk("lit_post_rst_data", rf_w_data_DM_WB, 32'h3333_4444);
        chk("lit_post_rst_stalls", 32'(st), 32'd1);

        // Random mix of ALU ops, loads and stores with random ack latency
        for (int i = 0; i < 200; i++) begin
            int          kind;
            int          r;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            r    = $urandom_range(0, 11);
            a    = $urandom;
            run_instr(kind == 1, kind == 2, 1'($urandom_range(0, 1)), a, $urandom,
                      5'($urandom_range(0, 31)), (r <= 9) ? r : -1, $urandom, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
